// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: funct3 access-size codes, stage FSM states and the access-fault check
// shared by the memory-access stage and its lane aligner.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Unsigned sizes only exist for loads; any unlisted code is illegal.
  function automatic logic access_fault(
    input logic [2:0] funct3,
    input logic [1:0] addr_lo,
    input logic       is_store
  );
    logic fault;
    case (funct3)
      F3_B:    fault = 1'b0;
      F3_H:    fault = addr_lo[0];
      F3_W:    fault = (addr_lo != 2'b00);
      F3_BU:   fault = is_store;
      F3_HU:   fault = is_store | addr_lo[0];
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// load_store_align: byte enables and replicated store lanes for stores, lane
// extraction with sign/zero extension for loads.
module load_store_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_word,
  output logic [3:0]            byte_en,
  output logic [DATA_WIDTH-1:0] store_lanes,
  output logic [DATA_WIDTH-1:0] load_result
);

  logic [DATA_WIDTH-1:0] shifted;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign shifted = load_word >> {addr_lo, 3'b000};

  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = '0;
    load_result = '0;
    case (funct3)
      F3_B: begin
        byte_en     = 4'b0001 << addr_lo;
        store_lanes = {4{store_data[7:0]}};
        load_result = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        byte_en     = 4'b0001 << addr_lo;
        load_result = {24'h0, shifted[7:0]};
      end
      F3_H: begin
        byte_en     = 4'b0011 << addr_lo;
        store_lanes = {2{store_data[15:0]}};
        load_result = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_HU: begin
        byte_en     = 4'b0011 << addr_lo;
        load_result = {16'h0, shifted[15:0]};
      end
      F3_W: begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
        load_result = load_word;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// mem_access_stage: RV32I load/store stage with a req/ack data-memory port; stalls
// upstream while an access is outstanding and registers the writeback outputs.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  validE_i,
  input  logic                  resultSRCE_i,
  input  logic                  memWriteE_i,
  input  logic                  regWriteE_i,
  input  logic [4:0]            rdE_i,
  input  logic [2:0]            funct3E_i,
  input  logic [DATA_WIDTH-1:0] ALUresultE_i,
  input  logic [DATA_WIDTH-1:0] RD2E_i,
  input  logic [DATA_WIDTH-1:0] addrSelectE_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  validW_o,
  output logic                  regWriteW_o,
  output logic [4:0]            rdW_o,
  output logic [DATA_WIDTH-1:0] resultW_o,
  output logic [DATA_WIDTH-1:0] addrSelectW_o,
  output logic                  errW_o
);

  state_t state, next_state;

  // Copy of the accepted memory op; upstream may change while in WAIT.
  logic [2:0]            cap_funct3, next_cap_funct3;
  logic [1:0]            cap_addr_lo, next_cap_addr_lo;
  logic [4:0]            cap_rd, next_cap_rd;
  logic                  cap_reg_write, next_cap_reg_write;
  logic                  cap_store, next_cap_store;
  logic [DATA_WIDTH-1:0] cap_addr_sel, next_cap_addr_sel;

  logic                  next_req, next_we;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [3:0]            next_be;
  logic [DATA_WIDTH-1:0] next_wdata;
  logic                  next_valid, next_reg_write, next_err;
  logic [4:0]            next_rd;
  logic [DATA_WIDTH-1:0] next_result, next_addr_sel;

  logic                  is_mem, is_store, fault;
  logic [2:0]            align_funct3;
  logic [1:0]            align_addr_lo;
  logic [3:0]            align_be;
  logic [DATA_WIDTH-1:0] align_lanes, align_load;

  assign is_mem   = validE_i & (resultSRCE_i | memWriteE_i);
  assign is_store = memWriteE_i & ~resultSRCE_i;
  assign fault    = access_fault(funct3E_i, ALUresultE_i[1:0], is_store);

  // In IDLE the aligner shapes the incoming store; in WAIT it formats the read word.
  assign align_funct3  = (state == WAIT) ? cap_funct3  : funct3E_i;
  assign align_addr_lo = (state == WAIT) ? cap_addr_lo : ALUresultE_i[1:0];

  load_store_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .funct3      (align_funct3),
    .addr_lo     (align_addr_lo),
    .store_data  (RD2E_i),
    .load_word   (mem_rdata_i),
    .byte_en     (align_be),
    .store_lanes (align_lanes),
    .load_result (align_load)
  );

  always_comb begin
    next_state         = state;
    stall_o            = 1'b0;
    next_req           = mem_req_o;
    next_we            = mem_we_o;
    next_addr          = mem_addr_o;
    next_be            = mem_be_o;
    next_wdata         = mem_wdata_o;
    next_valid         = 1'b0;
    next_reg_write     = 1'b0;
    next_err           = 1'b0;
    next_rd            = '0;
    next_result        = '0;
    next_addr_sel      = '0;
    next_cap_funct3    = cap_funct3;
    next_cap_addr_lo   = cap_addr_lo;
    next_cap_rd        = cap_rd;
    next_cap_reg_write = cap_reg_write;
    next_cap_store     = cap_store;
    next_cap_addr_sel  = cap_addr_sel;

    case (state)
      IDLE: begin
        if (validE_i) begin
          if (!is_mem) begin
            next_valid     = 1'b1;
            next_reg_write = regWriteE_i;
            next_rd        = rdE_i;
            next_result    = ALUresultE_i;
            next_addr_sel  = addrSelectE_i;
          end else if (fault) begin
            next_valid    = 1'b1;
            next_err      = 1'b1;
            next_rd       = rdE_i;
            next_addr_sel = addrSelectE_i;
          end else begin
            stall_o            = 1'b1;
            next_state         = WAIT;
            next_req           = 1'b1;
            next_we            = is_store;
            next_addr          = {ALUresultE_i[ADDR_WIDTH-1:2], 2'b00};
            next_be            = align_be;
            next_wdata         = is_store ? align_lanes : '0;
            next_cap_funct3    = funct3E_i;
            next_cap_addr_lo   = ALUresultE_i[1:0];
            next_cap_rd        = rdE_i;
            next_cap_reg_write = regWriteE_i & ~is_store;
            next_cap_store     = is_store;
            next_cap_addr_sel  = addrSelectE_i;
          end
        end
      end
      WAIT: begin
        stall_o = ~mem_ack_i;
        if (mem_ack_i) begin
          next_state     = IDLE;
          next_req       = 1'b0;
          next_we        = 1'b0;
          next_addr      = '0;
          next_be        = 4'b0000;
          next_wdata     = '0;
          next_valid     = 1'b1;
          next_reg_write = cap_reg_write;
          next_rd        = cap_rd;
          next_result    = cap_store ? '0 : align_load;
          next_addr_sel  = cap_addr_sel;
        end
      end
      default: next_state = IDLE;
    endcase

    if (!rst_n) stall_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_be_o      <= 4'b0000;
      mem_wdata_o   <= '0;
      validW_o      <= 1'b0;
      regWriteW_o   <= 1'b0;
      rdW_o         <= '0;
      resultW_o     <= '0;
      addrSelectW_o <= '0;
      errW_o        <= 1'b0;
      cap_funct3    <= '0;
      cap_addr_lo   <= '0;
      cap_rd        <= '0;
      cap_reg_write <= 1'b0;
      cap_store     <= 1'b0;
      cap_addr_sel  <= '0;
    end else begin
      state         <= next_state;
      mem_req_o     <= next_req;
      mem_we_o      <= next_we;
      mem_addr_o    <= next_addr;
      mem_be_o      <= next_be;
      mem_wdata_o   <= next_wdata;
      validW_o      <= next_valid;
      regWriteW_o   <= next_reg_write;
      rdW_o         <= next_rd;
      resultW_o     <= next_result;
      addrSelectW_o <= next_addr_sel;
      errW_o        <= next_err;
      cap_funct3    <= next_cap_funct3;
      cap_addr_lo   <= next_cap_addr_lo;
      cap_rd        <= next_cap_rd;
      cap_reg_write <= next_cap_reg_write;
      cap_store     <= next_cap_store;
      cap_addr_sel  <= next_cap_addr_sel;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage; sits directly downstream of the execute-to-memory pipeline register and consumes its outputs: ALU result, store data, memWrite, resultSRC.
- Performs RV32I loads and stores (byte, half and word) to data memory over a req/ack handshake.
- Formats load data (lane select and sign/zero extension) and stalls upstream while a memory access is outstanding.
- Registers the writeback-side outputs for the next stage.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- ADDR_WIDTH, 32, data-memory byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- validE_i  in  1  execute-stage instruction valid
- resultSRCE_i  in  1  1 = load (result from memory), 0 = ALU result
- memWriteE_i  in  1  store
- regWriteE_i  in  1  instruction writes rd
- rdE_i  in  5  destination register
- funct3E_i  in  3  access size/sign
- ALUresultE_i  in  DATA_WIDTH  effective address or ALU result
- RD2E_i  in  DATA_WIDTH  store data
- addrSelectE_i  in  DATA_WIDTH  passthrough (PC+4 / link value)
- stall_o  out  1  upstream must hold its inputs
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write request
- mem_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DATA_WIDTH  lane-aligned store data
- mem_ack_i  in  1  request accepted/completed; rdata valid same cycle
- mem_rdata_i  in  DATA_WIDTH  read word
- validW_o  out  1  writeback output valid (one-cycle pulse per instruction)
- regWriteW_o  out  1  register write enable
- rdW_o  out  5  destination register
- resultW_o  out  DATA_WIDTH  formatted load data or ALU result
- addrSelectW_o  out  DATA_WIDTH  passthrough
- errW_o  out  1  misaligned or illegal-size access

Behaviour:
- Memory op: validE_i && (resultSRCE_i || memWriteE_i). If both are set, treat as a load. Size comes from funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU for loads only).
- Fault: H with addr[0]=1, W with addr[1:0]!=0, or any other funct3 code. A faulting op issues no request and completes in 1 cycle with errW_o=1, regWriteW_o=0, resultW_o=0.
- FSM has two states:
  - IDLE: a non-memory or faulting op registers its outputs at the next edge (latency 1) and stall_o=0. A good memory op sets stall_o=1 combinationally, captures address, size, rd and data, moves to WAIT, and registers mem_req_o=1.
  - WAIT: mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are held stable until mem_ack_i. stall_o = !mem_ack_i. On ack, the next edge registers validW_o=1 with the formatted result (stores: regWriteW_o=0) and returns to IDLE with mem_req_o=0.
  - Minimum memory-op latency is 2 cycles.
- Store lanes:
  - B: be = 1<<addr[1:0], data = {4{byte}}.
  - H: be = 4'b0011<<addr[1:0], data = {2{half}}.
  - W: be = 4'b1111, data = RD2.
- Loads: select the byte/half at addr[1:0]; B/H sign-extend, BU/HU zero-extend.
- validW_o and errW_o are single-cycle pulses. If validE_i=0 in IDLE, the next cycle has validW_o=0 and regWriteW_o=0.
- mem_ack_i in IDLE is ignored.
- Upstream inputs are ignored while in WAIT; the captured copy is authoritative.
- Reset: when rst_n=0 at an edge, state goes to IDLE and every registered output is 0 (mem_req_o, mem_we_o, mem_be_o, validW_o, regWriteW_o, rdW_o, resultW_o, addrSelectW_o, errW_o, mem_addr_o, mem_wdata_o). Reset in WAIT abandons the access; a late ack is ignored. stall_o is 0 while rst_n=0.

Decomposition:
- Package mem_pkg: funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, WAIT}, helper function for misalignment check.
- One combinational sub-module, load_store_align: store byte-enable/lane generation and load extraction/extension.

Test Plan:
- Non-memory op: ALU result 0x0000_1234, regWrite=1, rd=5 -> next cycle validW_o=1, resultW_o=0x1234, rdW_o=5; stall_o never high; mem_req_o stays 0.
- LW at 0x100 with ack after 3 wait cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles; mem_addr_o=0x100 held; then resultW_o=0xDEADBEEF, validW_o pulse.
- LB at 0x103, rdata 0x80FF_FF00 -> resultW_o=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LH at 0x102 with rdata 0x8001_0000 -> 0xFFFF_8001.
- SB at 0x201 with RD2=0x1122_33AB -> mem_be_o=4'b0010, mem_wdata_o=0xABAB_ABAB, mem_we_o=1, regWriteW_o=0. SH at 0x202 -> be=4'b1100.
- LW at 0x102 -> no mem_req_o, next cycle errW_o=1, regWriteW_o=0. funct3=011 store -> errW_o=1.
- Reset asserted in WAIT, ack arriving 1 cycle later -> mem_req_o=0 after the edge, no validW_o, all outputs 0.
